// File: rtl/key_schedule_gen.sv
// Iterative AES-128 key expansion: rk0 is captured on start, then one round key is
// derived from the previous one every clock until rk10, using four byte S-boxes.
module key_schedule_gen #(
  parameter int NR      = 10,
  parameter int SCHED_W = 128 * (NR + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       cipher_key,
  output logic [SCHED_W-1:0] key,
  output logic               busy,
  output logic               done,
  output logic               key_valid
);

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q, state_n;
  logic [3:0]   round_q, round_n;
  logic [127:0] rk_q [0:NR];
  logic [127:0] prev_q;
  logic [127:0] next_rk;
  logic [31:0]  t_word;
  logic         done_n, valid_n, load, step;

  // prev_q mirrors the last written round key so the recurrence never muxes the schedule.
  always_comb begin
    t_word  = sub_word({prev_q[23:0], prev_q[31:24]}) ^ {rcon(round_q), 24'h0};
    next_rk[127:96] = prev_q[127:96] ^ t_word;
    next_rk[95:64]  = prev_q[95:64]  ^ next_rk[127:96];
    next_rk[63:32]  = prev_q[63:32]  ^ next_rk[95:64];
    next_rk[31:0]   = prev_q[31:0]   ^ next_rk[63:32];
  end

  always_comb begin
    state_n = state_q;
    round_n = round_q;
    done_n  = 1'b0;
    valid_n = key_valid;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          valid_n = 1'b0;
          round_n = 4'd1;
          state_n = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (round_q == LAST_ROUND) begin
          state_n = IDLE;
          round_n = 4'd0;
          done_n  = 1'b1;
          valid_n = 1'b1;
        end else begin
          round_n = round_q + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      round_q   <= 4'd0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      prev_q    <= '0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q   <= state_n;
      round_q   <= round_n;
      done      <= done_n;
      key_valid <= valid_n;
      if (load) begin
        // A new expansion wipes the old schedule so unwritten slices read as zero.
        for (int i = 1; i <= NR; i++) rk_q[i] <= '0;
        rk_q[0] <= cipher_key;
        prev_q  <= cipher_key;
      end else if (step) begin
        rk_q[round_q] <= next_rk;
        prev_q        <= next_rk;
      end
    end
  end

  assign busy = (state_q == EXPAND);

  for (genvar g = 0; g <= NR; g++) begin : g_key
    assign key[SCHED_W-1-128*g -: 128] = rk_q[g];
  end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Bench for key_schedule_gen: word-oriented key expansion model with an algebraic S-box,
// per-cycle expectations from the start/reset timing rules, and a done-driven scoreboard.
module tb_key_schedule_gen;
  localparam int SW = 1408;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [127:0]  cipher_key;
  logic [SW-1:0] key;
  logic          busy, done, key_valid;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  key_schedule_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cipher_key(cipher_key),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] xb, inv, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [SW-1:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [SW-1:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) s[SW-1-32*i -: 32] = w[i];
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_key(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    int bad;
    tests++;
    if (act !== exp) begin
      fails++;
      bad = 0;
      for (int r = 10; r >= 0; r--)
        if (act[SW-1-128*r -: 128] !== exp[SW-1-128*r -: 128]) bad = r;
      $display("FAIL %s cyc=%0d rk%0d got=%h want=%h", name, cyc, bad,
               act[SW-1-128*bad -: 128], exp[SW-1-128*bad -: 128]);
    end
  endtask

  // ---------------- model state and scoreboard ----------------
  int            acc_cyc = -1;
  logic [SW-1:0] acc_sched = '0;
  bit            pend_acc = 0, pend_rst = 0, mon_en = 0;
  int            pend_cyc = 0;
  logic [127:0]  pend_key = '0;
  logic [SW-1:0] exp_q [$];
  int            exp_cyc_q [$];

  // One cycle of stimulus; the model commits what the edge did right after that edge.
  task automatic drive(input logic s, input logic [127:0] k, input logic r);
    rst        = r;
    start      = s;
    cipher_key = k;
    if (r) pend_rst = 1;
    else if (s && (acc_cyc < 0 || cyc - acc_cyc >= 11)) begin
      pend_acc = 1;
      pend_cyc = cyc;
      pend_key = k;
    end
    @(posedge clk);
    #1;
    if (pend_rst) begin
      acc_cyc   = -1;
      acc_sched = '0;
      exp_q.delete();
      exp_cyc_q.delete();
      pend_rst  = 0;
      pend_acc  = 0;
    end else if (pend_acc) begin
      acc_cyc   = pend_cyc;
      acc_sched = expand(pend_key);
      exp_q.push_back(acc_sched);
      exp_cyc_q.push_back(pend_cyc + 11);
      pend_acc  = 0;
    end
  endtask

  always @(negedge clk) begin : monitor
    int            d;
    logic          eb, ed, ev;
    logic [SW-1:0] ek, got;
    int            c;
    if (mon_en) begin
      eb = 0; ed = 0; ev = 0; ek = '0;
      if (acc_cyc >= 0) begin
        d  = cyc - acc_cyc;
        eb = (d >= 1 && d <= 10);
        ed = (d == 11);
        ev = (d >= 11);
        for (int r = 0; r <= 10; r++)
          if (r < d) ek[SW-1-128*r -: 128] = acc_sched[SW-1-128*r -: 128];
      end
      chk_bit("busy", busy, eb);
      chk_bit("done", done, ed);
      chk_bit("key_valid", key_valid, ev);
      chk_key("key", key, ek);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done cyc=%0d got=1 want=0", cyc);
        end else begin
          got = exp_q.pop_front();
          c   = exp_cyc_q.pop_front();
          chk_key("done_sched", key, got);
          chk_int("done_cycle", cyc, c);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k1, k2;
    build_sbox();
    rst = 1'b1; start = 1'b0; cipher_key = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);

    // FIPS-197 key, cipher_key scrambled every cycle after the start edge
    drive(1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    repeat (12) drive(1'b0, rand128(), 1'b0);
    chk128("fips_rk0", key[1407 -: 128], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk128("fips_rk1", key[1279 -: 128], 128'ha0fafe1788542cb123a339392a6c7605);
    chk128("fips_rk10", key[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // all-zero key
    drive(1'b1, '0, 1'b0);
    repeat (12) drive(1'b0, '0, 1'b0);
    chk128("zero_rk1", key[1279 -: 128], 128'h62636363626363636263636362636363);
    chk128("zero_rk10", key[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // second start at cycle 5 is ignored
    k1 = rand128();
    k2 = rand128();
    drive(1'b1, k1, 1'b0);
    repeat (4) drive(1'b0, rand128(), 1'b0);
    drive(1'b1, k2, 1'b0);
    repeat (8) drive(1'b0, rand128(), 1'b0);
    chk_key("ignore_start_sched", key, expand(k1));

    // reset in cycle 6 of an expansion, then a clean restart
    drive(1'b1, rand128(), 1'b0);
    repeat (5) drive(1'b0, rand128(), 1'b0);
    drive(1'b0, rand128(), 1'b1);
    chk_key("abort_key_zero", key, '0);
    drive(1'b0, '0, 1'b0);
    k1 = rand128();
    drive(1'b1, k1, 1'b0);
    repeat (12) drive(1'b0, rand128(), 1'b0);
    chk_key("after_abort_sched", key, expand(k1));

    // start held high for 30 cycles with a changing key
    repeat (30) drive(1'b1, rand128(), 1'b0);
    repeat (12) drive(1'b0, '0, 1'b0);

    // random traffic with occasional resets
    repeat (200) drive($urandom_range(0, 3) == 0, rand128(), $urandom_range(0, 60) == 0);
    repeat (13) drive(1'b0, '0, 1'b0);

    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
